sw_debounce: RTL
================

Name: sw_debounce

Overview:
- Conditions raw DE0 slide-switch and pushbutton inputs before they reach the switch PIO input port (`in_port`).
- Synchronizes each bit to `clk`, rejects contact bounce with a per-bit stability counter, and presents clean levels plus one-cycle edge pulses.
- Sits between the top-level switch pins and the Qsys PIO input peripheral.

Parameters:
- WIDTH, 4, number of switch bits handled (independent per-bit logic).
- STABLE_CYCLES, 500000, consecutive clk cycles a synchronized level must hold before it is accepted (10 ms at 50 MHz); legal range 2 to 2^24.
- RESET_VALUE, 0, WIDTH-bit value loaded into `sw_clean` at reset.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- sw_raw  input  WIDTH  asynchronous switch pins.
- sw_clean  output  WIDTH  debounced level; drives PIO `in_port`.
- sw_rise  output  WIDTH  one-cycle pulse per bit on accepted 0->1.
- sw_fall  output  WIDTH  one-cycle pulse per bit on accepted 1->0.
- sw_changed  output  1  OR of all `sw_rise` and `sw_fall` bits, same cycle.

Behaviour:
- Reset state (async assert, sync release):
  - sync stages s1 and s2 = RESET_VALUE.
  - `sw_clean` = RESET_VALUE.
  - all counters = 0.
  - `sw_rise`, `sw_fall`, `sw_changed` = 0.
  - all per-bit FSMs = STABLE.
- Synchronizer: 2-FF per bit, s1 <= `sw_raw`, s2 <= s1. No other logic may use `sw_raw` directly.
- Counter width: CNT_W = clog2(STABLE_CYCLES). Counter never exceeds STABLE_CYCLES-1, so there is no wrap-around.
- Per-bit FSM, states STABLE and PENDING, evaluated each rising edge:
  - STABLE, s2 == clean: stay; cnt = 0.
  - STABLE, s2 != clean: go PENDING; cnt <= 1.
  - PENDING, s2 == clean: bounce rejected; go STABLE; cnt <= 0; no pulse.
  - PENDING, s2 != clean, cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - PENDING, s2 != clean, cnt == STABLE_CYCLES-1: clean <= s2; cnt <= 0; go STABLE; assert `sw_rise` or `sw_fall` for exactly the next cycle.
- Latency: a clean step on `sw_raw` that is first sampled at edge k appears on `sw_clean` after edge k+STABLE_CYCLES+1. That is STABLE_CYCLES+2 edges counting edge k.
- Glitch rejection: any s2 excursion lasting fewer than STABLE_CYCLES cycles leaves `sw_clean` unchanged and produces no pulses.
- Pulses:
  - Registered and aligned with the `sw_clean` update: the pulse is high in the same cycle `sw_clean` first shows the new value.
  - `sw_rise` and `sw_fall` for the same bit are never both 1.
- Independence: bits never share counters. Simultaneous acceptance on several bits asserts several pulse bits in one cycle, with a single `sw_changed` high.
- Reset mid-operation: any PENDING count is discarded. After release, the input is re-qualified from RESET_VALUE; no pulse is generated by reset itself.
- Fully synchronous outputs; no combinational path from `sw_raw` to any output.

Test Plan:
- Reset/idle: STABLE_CYCLES=4, RESET_VALUE=0, `sw_raw`=0 -> `sw_clean`=0, no pulses for 50 cycles after reset release.
- Clean step: STABLE_CYCLES=4, bit0 0->1 sampled at edge k -> `sw_clean`[0]=1 after edge k+5; `sw_rise`[0] and `sw_changed` high for exactly that one cycle; `sw_fall`=0 throughout.
- Bounce: bit1 toggles 1,0,1,0 at 1-cycle and 2-cycle intervals, then holds 1 -> `sw_clean`[1] rises only STABLE_CYCLES+2 edges after the final settling edge; exactly one `sw_rise`[1] pulse.
- Short glitch: bit2 high for 3 cycles (less than 4) -> `sw_clean`[2] stays 0; no pulses.
- Simultaneous: bits 0 and 3 go 1->0 at the same edge (both previously accepted as 1) -> `sw_fall`=4'b1001 in one cycle; `sw_changed` high for one cycle.
- Reset mid-count: bit0 PENDING with cnt=2, assert `reset_n` low for 1 cycle -> `sw_clean`=RESET_VALUE immediately; after release, a held level needs the full 6 edges to be accepted; no spurious pulse.

Source files
------------

// File: rtl/sw_debounce.sv
// Switch/pushbutton debouncer: 2-FF synchronizer per bit followed by a per-bit stability counter FSM.
// Latency: a step first sampled at edge k shows on sw_clean (and its pulse) after edge k+STABLE_CYCLES+1.
// Backpressure: none; free-running conditioner, every output is registered and updates each cycle.
module sw_debounce #(
    parameter int               WIDTH         = 4,
    parameter int               STABLE_CYCLES = 500000,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);

    // The counter only ever holds 0 .. STABLE_CYCLES-1, so clog2 bits never wrap.
    localparam int              CNT_W    = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_e;

    // Synchronizer stages; sync2_q is the only view of the pins the FSMs get.
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    // Per-bit acceptance strobe: the new level has now held for STABLE_CYCLES edges.
    logic [WIDTH-1:0] accept;

    logic             changed_q;

    // Two-flop synchronizer, reset to the same value as sw_clean so release is quiet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= RESET_VALUE;
            sync2_q <= RESET_VALUE;
        end else begin
            sync1_q <= sw_raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        state_e           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             clean_q;
        logic             rise_q;
        logic             fall_q;
        logic             differs;

        assign differs   = (sync2_q[i] != clean_q);
        assign accept[i] = (state_q == ST_PENDING) && differs && (cnt_q == CNT_LAST);

        // Stability FSM: any return to the clean level while pending throws the count away.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= ST_STABLE;
                cnt_q   <= '0;
                clean_q <= RESET_VALUE[i];
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                case (state_q)
                    ST_STABLE: begin
                        if (differs) begin
                            state_q <= ST_PENDING;
                            cnt_q   <= CNT_ONE;
                        end else begin
                            cnt_q   <= '0;
                        end
                    end
                    ST_PENDING: begin
                        if (!differs) begin
                            state_q <= ST_STABLE;
                            cnt_q   <= '0;
                        end else if (accept[i]) begin
                            state_q <= ST_STABLE;
                            cnt_q   <= '0;
                            clean_q <= sync2_q[i];
                            rise_q  <= sync2_q[i];
                            fall_q  <= ~sync2_q[i];
                        end else begin
                            cnt_q   <= cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_q <= ST_STABLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end

        assign sw_clean[i] = clean_q;
        assign sw_rise[i]  = rise_q;
        assign sw_fall[i]  = fall_q;
    end

    // Summary strobe registered from the same acceptance terms so it lines up with the pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= |accept;
        end
    end

    assign sw_changed = changed_q;

endmodule
